// File: rtl/aes_pkg.sv
// Shared AES-128 types: cipher block, round index, controller FSM encoding.
// Imported by the round controller, the stage units and the key-expansion store.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef logic [127:0] aes_block_t;
  typedef logic [3:0]   aes_round_t;

  typedef enum logic [2:0] {
    IDLE,
    ARK,
    SB,
    SR,
    MC,
    DONE
  } aes_ctrl_state_t;

  // Saturating step: the round index must never pass the last round.
  function automatic aes_round_t round_inc(aes_round_t r, aes_round_t last);
    return (r >= last) ? r : r + 4'd1;
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round index counter: clear wins over increment, saturates at NUM_ROUNDS.
// Zero latency on last (decode of the register); no backpressure.
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] round_idx,
  output logic       last
);

  localparam aes_round_t LAST_ROUND = aes_round_t'(NUM_ROUNDS);

  aes_round_t cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= round_inc(cnt, LAST_ROUND);
    end
  end

  assign round_idx = cnt;
  assign last      = (cnt == LAST_ROUND);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: 40 stage cycles + 1 DONE cycle; ARK stalls while key_valid is low,
// start is ignored while busy. Optional abort input under AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic         key_valid,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic         abort,
`endif
  input  logic [127:0] sb_out,
  input  logic [127:0] sr_out,
  input  logic [127:0] mc_out,
  input  logic [127:0] ark_out,
  output logic [127:0] state_q,
  output logic         sb_enable,
  output logic         sr_enable,
  output logic         mc_enable,
  output logic         ark_enable,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  aes_ctrl_state_t state, state_nxt;
  aes_block_t      blk_nxt;
  logic            cnt_clr;
  logic            cnt_inc;
  logic            last_round;

  aes_round_cnt #(
    .NUM_ROUNDS (NUM_ROUNDS)
  ) u_round_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .round_idx (round_idx),
    .last      (last_round)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      state_q <= '0;
    end else begin
      state   <= state_nxt;
      state_q <= blk_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    blk_nxt   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          blk_nxt   = data_in;
          cnt_clr   = 1'b1;
          state_nxt = ARK;
        end
      end
      ARK: begin
        // Round index advances here, so SB/SR/MC run with the index of their own round.
        if (key_valid) begin
          blk_nxt = ark_out;
          if (last_round) begin
            state_nxt = DONE;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = SB;
          end
        end
      end
      SB: begin
        blk_nxt   = sb_out;
        state_nxt = SR;
      end
      SR: begin
        blk_nxt   = sr_out;
        state_nxt = last_round ? ARK : MC;
      end
      MC: begin
        blk_nxt   = mc_out;
        state_nxt = ARK;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef AES_ROUND_CTRL_ABORT_EN
    if (abort && (state != IDLE)) begin
      state_nxt = IDLE;
      blk_nxt   = '0;
      cnt_clr   = 1'b1;
      cnt_inc   = 1'b0;
    end
`endif
  end

  assign ark_enable = (state == ARK);
  assign sb_enable  = (state == SB);
  assign sr_enable  = (state == SR);
  assign mc_enable  = (state == MC);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  a_enable_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({sb_enable, sr_enable, mc_enable, ark_enable}));

  a_round_bound: assert property (@(posedge clk) disable iff (rst)
    round_idx <= 4'(NUM_ROUNDS));

  a_no_final_mc: assert property (@(posedge clk) disable iff (rst)
    !(mc_enable && last_round));

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with behavioural AES stage units and key store.
// Vector table plus hand-written reset/abort sequences; ciphertexts via scoreboard.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] data_in;
  logic         key_valid;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic         abort;
`endif
  logic [127:0] sb_out, sr_out, mc_out, ark_out;
  logic [127:0] state_q;
  logic         sb_enable, sr_enable, mc_enable, ark_enable;
  logic [3:0]   round_idx;
  logic         busy, done;

  localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ct;
    int           stall_rnd;
    int           stall_len;
    int           busy_cyc;
    int           idle_cyc;
  } vec_t;

  vec_t         vecs[5];
  logic [127:0] rkey[16];
  logic [127:0] sb_q[$];
  logic [3:0]   seq_en[40];
  int           seq_rnd[40];
  int           n_chk = 0;
  int           n_pass = 0;

  aes_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .key_valid  (key_valid),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .sb_out     (sb_out),
    .sr_out     (sr_out),
    .mc_out     (mc_out),
    .ark_out    (ark_out),
    .state_q    (state_q),
    .sb_enable  (sb_enable),
    .sr_enable  (sr_enable),
    .mc_enable  (mc_enable),
    .ark_enable (ark_enable),
    .round_idx  (round_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x; r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkey[0];
    for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rkey[r];
    return shift_rows(sub_bytes(s)) ^ rkey[10];
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rkey[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  assign sb_out  = sub_bytes(state_q);
  assign sr_out  = shift_rows(state_q);
  assign mc_out  = mix_columns(state_q);
  assign ark_out = state_q ^ rkey[round_idx];

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_blk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input vec_t v);
    int k, ptr, seq_err, hold_err, stalled, n_late;
    logic [127:0] snap, exp_ct;
    logic stall_now;
    ptr = 0; seq_err = 0; hold_err = 0; stalled = 0; n_late = 0; snap = '0;
    data_in = v.pt; start = 1'b1; key_valid = 1'b1;
    sb_q.push_back(v.ct);
    tick();
    start = 1'b0;
    k = 1;
    while (!done && k < 200) begin
      if (ptr >= 40) seq_err++;
      else if ({ark_enable, mc_enable, sr_enable, sb_enable} != seq_en[ptr] ||
               int'(round_idx) != seq_rnd[ptr]) seq_err++;
      if (mc_enable && round_idx == 4'd10) seq_err++;
      if (!busy) seq_err++;
      if (ark_enable && int'(round_idx) == v.stall_rnd && stalled > 0 && state_q != snap) hold_err++;
      stall_now = ark_enable && int'(round_idx) == v.stall_rnd && stalled < v.stall_len;
      if (stall_now) begin
        if (stalled == 0) snap = state_q;
        stalled++;
        key_valid = 1'b0;
      end else begin
        key_valid = 1'b1;
        ptr++;
      end
      if (k == v.busy_cyc) begin
        start = 1'b1; data_in = ~v.pt;
      end else begin
        start = 1'b0; data_in = v.pt;
      end
      tick();
      k++;
    end
    start = 1'b0; key_valid = 1'b1; data_in = v.pt;
    check_int("latency", k, 41 + v.stall_len);
    exp_ct = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    check_blk("ciphertext", state_q, exp_ct);
    check_int("enable_seq", seq_err, 0);
    if (v.stall_len > 0) begin
      check_int("stall_hold", hold_err, 0);
      check_int("stall_cycles", stalled, v.stall_len);
    end
    tick();
    check_int("done_pulse", int'(done), 0);
    check_int("idle_busy", int'(busy), 0);
    for (int i = 0; i < v.idle_cyc; i++) begin
      n_late += int'(done) + int'(busy);
      tick();
    end
    if (v.idle_cyc > 0) check_int("no_second_done", n_late, 0);
  endtask

  initial begin
    int n, cnt;
    logic [127:0] dummy;
    rst = 1'b1; start = 1'b0; key_valid = 1'b1; data_in = '0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    expand_key(KEY);
    n = 0;
    seq_en[n] = 4'b1000; seq_rnd[n] = 0; n++;
    for (int r = 1; r <= 10; r++) begin
      seq_en[n] = 4'b0001; seq_rnd[n] = r; n++;
      seq_en[n] = 4'b0010; seq_rnd[n] = r; n++;
      if (r < 10) begin
        seq_en[n] = 4'b0100; seq_rnd[n] = r; n++;
      end
      seq_en[n] = 4'b1000; seq_rnd[n] = r; n++;
    end

    vecs[0] = '{FIPS_PT, FIPS_CT, -1, 0, -1, 0};
    vecs[1] = '{FIPS_PT, FIPS_CT, 5, 3, -1, 0};
    vecs[2] = '{FIPS_PT, FIPS_CT, -1, 0, 10, 45};
    vecs[3] = '{128'h3243f6a8885a308d313198a2e0370734, '0, 0, 2, -1, 0};
    vecs[3].ct = aes_ref(vecs[3].pt);
    vecs[4] = '{{128{1'b1}}, '0, 10, 1, -1, 2};
    vecs[4].ct = aes_ref(vecs[4].pt);

    tick();
    tick();
    check_blk("reset_state_q", state_q, '0);
    check_int("reset_round", int'(round_idx), 0);
    check_int("reset_ctrl", int'({sb_enable, sr_enable, mc_enable, ark_enable, busy, done}), 0);
    rst = 1'b0;
    tick();
    check_int("idle_no_start", int'(busy), 0);

    for (int i = 0; i < 5; i++) run_block(vecs[i]);

    // Reset in the middle of round 4 discards the block.
    data_in = vecs[4].pt; start = 1'b1;
    sb_q.push_back(vecs[4].ct);
    tick();
    start = 1'b0;
    cnt = 0;
    while (!(sr_enable && round_idx == 4'd4) && cnt < 100) begin
      tick();
      cnt++;
    end
    check_int("reach_round4", int'(sr_enable), 1);
    #2 rst = 1'b1;
    #1;
    check_blk("midrst_state_q", state_q, '0);
    check_int("midrst_round", int'(round_idx), 0);
    check_int("midrst_ctrl", int'({sb_enable, sr_enable, mc_enable, ark_enable, busy, done}), 0);
    dummy = sb_q.pop_front();
    tick();
    rst = 1'b0;
    tick();
    run_block(vecs[0]);

`ifdef AES_ROUND_CTRL_ABORT_EN
    data_in = vecs[3].pt; start = 1'b1;
    sb_q.push_back(vecs[3].ct);
    tick();
    start = 1'b0;
    cnt = 0;
    while (!(sr_enable && round_idx == 4'd7) && cnt < 100) begin
      tick();
      cnt++;
    end
    check_int("reach_round7", int'(sr_enable), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_int("abort_busy", int'(busy), 0);
    check_blk("abort_state_q", state_q, '0);
    check_int("abort_round", int'(round_idx), 0);
    cnt = 0;
    repeat (45) begin
      cnt += int'(done);
      tick();
    end
    check_int("abort_no_done", cnt, 0);
    dummy = sb_q.pop_front();
    run_block(vecs[3]);
`endif

    check_int("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
